// File: rtl/jpeg_stream_pkg.sv
// Shared state encoding and marker constants for the JPEG output sequencer.
// Restart states exist only when JPEG_RESTART_MARKERS_EN is defined.
package jpeg_stream_pkg;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] MARKER_EOI    = 8'hD9;
  localparam logic [7:0] MARKER_RST0   = 8'hD0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_SCAN,
    ST_DRAIN,
    ST_EOI_FF,
    ST_EOI_D9
`ifdef JPEG_RESTART_MARKERS_EN
    ,
    ST_RST_DRAIN,
    ST_RST_FF,
    ST_RST_MK
`endif
  } seq_state_e;

  function automatic logic [7:0] rst_marker(input logic [2:0] idx);
    return MARKER_RST0 | {5'b00000, idx};
  endfunction

endpackage

// File: rtl/stream_quiet_timer.sv
// Counts consecutive idle stuffer cycles while armed; drained is a registered
// flag raised one cycle after the count reaches QUIET.
module stream_quiet_timer #(
  parameter int unsigned QUIET = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic activity,
  input  logic arm,
  output logic drained
);

  localparam int unsigned CW = $clog2(QUIET + 1);
  localparam logic [CW-1:0] QUIET_MAX = CW'(QUIET);

  logic [CW-1:0] quiet_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      quiet_cnt <= '0;
      drained   <= 1'b0;
    end else if (arm) begin
      if (activity) begin
        quiet_cnt <= '0;
        drained   <= 1'b0;
      end else begin
        if (quiet_cnt != QUIET_MAX) quiet_cnt <= quiet_cnt + 1'b1;
        drained <= (quiet_cnt == QUIET_MAX);
      end
    end
  end

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// JPEG output scheduler: header ROM, stuffed scan pass-through, EOI marker.
// Restart-marker insertion is built only with JPEG_RESTART_MARKERS_EN defined.
module jpeg_stream_sequencer
  import jpeg_stream_pkg::*;
#(
  parameter int unsigned HDR_LEN = 623,
  parameter int unsigned HDR_AW  = 10,
  parameter int unsigned QUIET   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  output logic [HDR_AW-1:0] hdr_addr,
  input  logic [7:0]        hdr_data,
  input  logic              scan_valid,
  input  logic [7:0]        scan_data,
  input  logic              scan_done,
  input  logic              rst_req,
  output logic              rst_ack,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  localparam logic [HDR_AW:0] HDR_LAST = (HDR_AW + 1)'(HDR_LEN);

  seq_state_e state, next_state;
  logic [HDR_AW:0] hdr_cnt;
  logic drain_arm, drained, pass_st;
  logic valid_d, ack_d, done_d, err_d;
  logic [7:0] data_d;

`ifdef JPEG_RESTART_MARKERS_EN
  logic [2:0] rst_idx;
  assign drain_arm = (state == ST_DRAIN) || (state == ST_RST_DRAIN);
`else
  logic unused_rst_req;
  assign unused_rst_req = rst_req;
  assign drain_arm = (state == ST_DRAIN);
`endif

  assign pass_st  = (state == ST_SCAN) || drain_arm;
  // hdr_cnt runs one ahead of the emitted byte to cover the ROM read latency
  assign hdr_addr = hdr_cnt[HDR_AW-1:0];

  stream_quiet_timer #(.QUIET(QUIET)) u_quiet (
    .clock    (clock),
    .reset    (reset),
    .clear    (!drain_arm),
    .activity (scan_valid),
    .arm      (drain_arm),
    .drained  (drained)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (frame_start) next_state = ST_HDR;
      ST_HDR:    if (hdr_cnt == HDR_LAST) next_state = ST_SCAN;
      ST_SCAN: begin
        if (scan_done) next_state = ST_DRAIN;
`ifdef JPEG_RESTART_MARKERS_EN
        else if (rst_req) next_state = ST_RST_DRAIN;
`endif
      end
      ST_DRAIN:  if (drained && !scan_valid) next_state = ST_EOI_FF;
      ST_EOI_FF: next_state = ST_EOI_D9;
      ST_EOI_D9: next_state = ST_IDLE;
`ifdef JPEG_RESTART_MARKERS_EN
      ST_RST_DRAIN: if (drained && !scan_valid) next_state = ST_RST_FF;
      ST_RST_FF:    next_state = ST_RST_MK;
      ST_RST_MK:    next_state = ST_SCAN;
`endif
      default:   next_state = ST_IDLE;
    endcase
  end

  // Marker bytes are keyed on the state being entered so they register on entry.
  always_comb begin
    valid_d = 1'b0;
    data_d  = 8'h00;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = error;
    if (scan_valid && !pass_st) err_d = 1'b1;
    case (next_state)
      ST_EOI_FF: begin valid_d = 1'b1; data_d = MARKER_PREFIX; end
      ST_EOI_D9: begin valid_d = 1'b1; data_d = MARKER_EOI; end
`ifdef JPEG_RESTART_MARKERS_EN
      ST_RST_FF: begin valid_d = 1'b1; data_d = MARKER_PREFIX; end
      ST_RST_MK: begin valid_d = 1'b1; data_d = rst_marker(rst_idx); ack_d = 1'b1; end
`endif
      default: begin
        if ((state == ST_HDR) && (hdr_cnt != '0)) begin
          valid_d = 1'b1;
          data_d  = hdr_data;
        end else if (pass_st) begin
          valid_d = scan_valid;
          data_d  = scan_data;
        end
        done_d = (state == ST_EOI_D9);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      rst_ack    <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      hdr_cnt    <= '0;
    end else begin
      out_valid  <= valid_d;
      out_data   <= data_d;
      rst_ack    <= ack_d;
      frame_done <= done_d;
      error      <= err_d;
      busy       <= (next_state != ST_IDLE);
      hdr_cnt    <= ((state == ST_HDR) && (next_state == ST_HDR)) ? hdr_cnt + 1'b1 : '0;
    end
  end

`ifdef JPEG_RESTART_MARKERS_EN
  always_ff @(posedge clock) begin
    if (reset)                                rst_idx <= '0;
    else if ((state == ST_IDLE) && frame_start) rst_idx <= '0;
    else if (state == ST_RST_FF)              rst_idx <= rst_idx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Self-checking bench for jpeg_stream_sequencer (HDR_LEN=4, QUIET=4); restart
// scenarios adapt to whether JPEG_RESTART_MARKERS_EN is defined.
module tb_jpeg_stream_sequencer;

  localparam int unsigned HDR_LEN = 4;
  localparam int unsigned HDR_AW  = 2;
  localparam int unsigned QUIET   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0, scan_valid = 1'b0, scan_done = 1'b0, rst_req = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic [7:0] hdr_data;
  logic [HDR_AW-1:0] hdr_addr;
  logic rst_ack, out_valid, busy, frame_done, error;
  logic [7:0] out_data;

  logic [7:0] rom [HDR_LEN] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0};

  always #5 clock = ~clock;
  always @(posedge clock) hdr_data <= rom[hdr_addr];

  jpeg_stream_sequencer #(.HDR_LEN(HDR_LEN), .HDR_AW(HDR_AW), .QUIET(QUIET)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .hdr_addr(hdr_addr),
    .hdr_data(hdr_data), .scan_valid(scan_valid), .scan_data(scan_data),
    .scan_done(scan_done), .rst_req(rst_req), .rst_ack(rst_ack),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .frame_done(frame_done), .error(error)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int ack_cnt = 0;

  always @(negedge clock) begin
    if (out_valid) got.push_back(out_data);
    if (rst_ack) ack_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input logic fs, input logic sv, input logic [7:0] sd,
                      input logic dn, input logic rr);
    @(negedge clock);
    frame_start = fs; scan_valid = sv; scan_data = sd; scan_done = dn; rst_req = rr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    for (int i = 0; i < 40 && !frame_done; i++) idle();
    check({name, " frame_done"}, frame_done, 1);
  endtask

  task automatic compare_stream(input string name);
    check({name, " length"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s byte %0d", name, i), got[i], exp_q[i]);
  endtask

  // Reference: header, then every scan byte in order, FF Dn after each accepted
  // restart request, FF D9 at the end; Dn counts from D0 per frame, mod 8.
  task automatic run_frame(input string name, input int n_rst, input int n_bytes);
    int rst_n = 0;
    int acks0 = ack_cnt;
    int k;
    logic [7:0] b;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (HDR_LEN + 1) idle();
    k = (n_rst > 0) ? n_bytes / (n_rst + 1) : n_bytes + 1;
    for (int i = 0; i < n_bytes; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      b = 8'($urandom);
      tick(1'b0, 1'b1, b, 1'b0, 1'b0);
      exp_q.push_back(b);
      if (rst_n < n_rst && (i + 1) % k == 0) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          tick(1'b0, 1'b1, b, 1'b0, 1'b1);
          exp_q.push_back(b);
        end else begin
          tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        repeat ($urandom_range(0, 2)) begin
          b = 8'($urandom);
          tick(1'b0, 1'b1, b, 1'b0, 1'b0);
          exp_q.push_back(b);
        end
`ifdef JPEG_RESTART_MARKERS_EN
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD0 | 8'(rst_n % 8));
        for (int j = 0; j < 40 && !rst_ack; j++) idle();
        check($sformatf("%s rst_ack %0d", name, rst_n), rst_ack, 1);
        idle();
`endif
        rst_n++;
      end
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    wait_frame_done(name);
    idle();
    compare_stream(name);
`ifdef JPEG_RESTART_MARKERS_EN
    check({name, " rst_ack count"}, ack_cnt - acks0, n_rst);
`else
    check({name, " rst_ack count"}, ack_cnt - acks0, 0);
`endif
    check({name, " error"}, error, 0);
    check({name, " busy"}, busy, 0);
  endtask

  typedef struct {
    logic fs, sv; logic [7:0] sd; logic dn, rr;
    logic ov; logic [7:0] od; logic bsy, fd, er;
  } vec_t;

  function automatic vec_t v(input logic fs, input logic sv, input logic [7:0] sd,
                             input logic dn, input logic rr, input logic ov,
                             input logic [7:0] od, input logic bsy, input logic fd,
                             input logic er);
    vec_t r;
    r.fs = fs; r.sv = sv; r.sd = sd; r.dn = dn; r.rr = rr;
    r.ov = ov; r.od = od; r.bsy = bsy; r.fd = fd; r.er = er;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int acks0;

    // Rows: inputs sampled at edge i, outputs expected just after edge i.
    tbl.push_back(v(1,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hFF,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hD8,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hFF,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hE0,1,0,0));
    tbl.push_back(v(0,1,8'h12,0,0, 1,8'h12,1,0,0));
    tbl.push_back(v(1,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,1,8'hFF,0,0, 1,8'hFF,1,0,0));
    tbl.push_back(v(0,1,8'h00,0,0, 1,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,1,8'h34,1,0, 1,8'h34,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,1, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,1,8'h56,0,0, 1,8'h56,1,0,0));
    repeat (5) tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hFF,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 1,8'hD9,1,0,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,0,0, 0,8'h00,0,0,0));

    do_reset();
    check("reset outputs", {out_valid, out_data, hdr_addr, rst_ack, frame_done, error, busy}, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].fs, tbl[i].sv, tbl[i].sd, tbl[i].dn, tbl[i].rr);
      check($sformatf("table row %0d", i),
            {out_valid, (out_valid ? out_data : 8'h00), busy, frame_done, error},
            {tbl[i].ov, tbl[i].od, tbl[i].bsy, tbl[i].fd, tbl[i].er});
    end

    // Scan byte during header: discarded, header intact, error sticky until reset.
    do_reset();
    got.delete();
    exp_q.delete();
    for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    tick(1'b0, 1'b1, 8'hAB, 1'b0, 1'b0);
    check("error after hdr scan byte", error, 1);
    repeat (3) idle();
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    wait_frame_done("hdr error frame");
    idle();
    compare_stream("hdr error frame");
    check("error still set", error, 1);
    do_reset();
    check("error cleared by reset", error, 0);

    // Reset mid-header, then a full frame; scan_done with rst_req picks EOI.
    got.delete();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) idle();
    check("hdr_addr mid header", hdr_addr, 3);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("mid-frame reset outputs",
          {out_valid, out_data, hdr_addr, rst_ack, frame_done, error, busy}, 0);
    got.delete();
    exp_q.delete();
    for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
    acks0 = ack_cnt;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (HDR_LEN + 1) idle();
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    wait_frame_done("done+rst frame");
    idle();
    compare_stream("done+rst frame");
    check("done+rst no rst_ack", ack_cnt - acks0, 0);

    run_frame("nine restarts", 9, 20);
    run_frame("next frame restart", 1, 4);
    for (int f = 0; f < 4; f++)
      run_frame($sformatf("random frame %0d", f), $urandom_range(0, 3), $urandom_range(4, 15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_stream_sequencer.md
# jpeg_stream_sequencer

Top-level JPEG output scheduler: shares a single byte output port among three sources, in order: the header ROM (unstuffed), the byte-stuffed entropy stream coming from the stuffer, and the EOI/RST marker generator (unstuffed). Sits between the stuffer and the output FIFO/UART. Because the stuffer has no backpressure, markers are only inserted after a quiet window on the stuffer output.

## Interface
- HDR_LEN, 623: header bytes emitted from ROM, ≥2
- HDR_AW, 10: header ROM address width; 2^HDR_AW ≥ HDR_LEN
- QUIET, 4: consecutive idle stuffer cycles that define "drained", ≥1
- clock  in  1  all state updates on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  pulse; accepted only in IDLE
- hdr_addr  out  HDR_AW  ROM read address, registered; ROM has 1-cycle read latency
- hdr_data  in  8  ROM data for the address presented on the previous edge
- scan_valid  in  1  stuffer output byte valid
- scan_data  in  8  stuffer output byte
- scan_done  in  1  pulse from entropy coder: final bits flushed into the stuffer
- rst_req  in  1  pulse: restart interval reached, coder paused
- rst_ack  out  1  1-cycle pulse: RST marker emitted, coder may resume
- out_valid  out  1  out_data valid this cycle
- out_data  out  8  output byte
- busy  out  1  state ≠ IDLE
- frame_done  out  1  1-cycle pulse after the EOI second byte
- error  out  1  sticky: scan byte arrived outside a scan-accepting state

## Operation
- States: IDLE, HDR, SCAN, DRAIN, EOI_FF, EOI_D9, RST_DRAIN, RST_FF, RST_MK.
- IDLE: hdr_addr held at 0. frame_start → HDR; hdr_addr increments; rst_idx cleared to 0.
- HDR: hdr_addr increments each cycle. out_data ← hdr_data with out_valid=1, for exactly HDR_LEN consecutive cycles. After the last byte → SCAN; hdr_addr returns to 0.
- SCAN, DRAIN, RST_DRAIN: out_valid ← scan_valid and out_data ← scan_data. Every stuffer byte is forwarded; none are dropped.
- scan_done in SCAN → DRAIN.
- DRAIN / RST_DRAIN: the quiet counter resets to 0 on entry and on any scan_valid, and increments otherwise. Reaching QUIET moves DRAIN → EOI_FF and RST_DRAIN → RST_FF.
- EOI_FF emits 0xFF, EOI_D9 emits 0xD9, then → IDLE with frame_done=1 in the same cycle as the IDLE entry.
- rst_req in SCAN → RST_DRAIN. RST_FF emits 0xFF. RST_MK emits 0xD0|rst_idx with rst_ack=1, rst_idx ← rst_idx+1 (3-bit wrap, 7→0), then → SCAN.
- scan_valid in IDLE, HDR, EOI_*, RST_FF or RST_MK: byte discarded, error ← 1, state unaffected.
- scan_done and rst_req in the same cycle: scan_done wins and rst_req is dropped.
- rst_req outside SCAN is ignored. frame_start outside IDLE is ignored.
- Reset, including mid-frame: state IDLE; out_valid, out_data, hdr_addr, rst_ack, frame_done, error, rst_idx and the quiet counter all 0; busy 0.

## Timing
- All outputs are registered.
- frame_start sampled at edge E0 → header byte 0 is valid after edge E2.
- Header bytes 1..HDR_LEN-1 follow back-to-back.
- Scan pass-through latency: 1 cycle (scan byte at edge E → out at E+1).
- scan_done at edge E with no further scan bytes → out 0xFF after edge E+QUIET+2, 0xD9 one cycle later, frame_done one cycle after 0xD9.
- Restart follows the same drain timing as EOI. rst_ack is coincident with the 0xD0+n byte.
- Throughput: at most one byte per cycle, with no bubbles inside the header or a marker.

## Configuration
- JPEG_RESTART_MARKERS_EN defined: restart path as described above.
- Not defined: rst_req ignored and rst_ack tied 0. RST_* states and rst_idx are not built. Ports remain present.

## Structure
- Package jpeg_stream_pkg:
  - state encoding
  - marker constants MARKER_PREFIX=8'hFF, MARKER_EOI=8'hD9, MARKER_RST0=8'hD0
- Sub-module stream_quiet_timer: QUIET-parameterised counter with inputs clear, activity and arm; output drained. Used by both DRAIN and RST_DRAIN.
- The header ROM lives outside this block, instantiated by the parent.

## Test plan
- HDR_LEN=4, ROM={FF,D8,FF,E0}, frame_start → out FF,D8,FF,E0 on 4 consecutive cycles starting 2 cycles after frame_start; busy=1.
- Scan bytes 12,FF,00,34 with gaps, then scan_done, QUIET=4 → bytes forwarded 1 cycle late, then FF,D9 exactly 4 idle cycles after the last byte; frame_done pulse; busy=0.
- During DRAIN, scan byte 56 at quiet count 3 → 56 forwarded, counter restarts, EOI delayed by a further 4 idle cycles.
- JPEG_RESTART_MARKERS_EN, 9 rst_req pulses in one frame → markers D0..D7 then D0, each preceded by FF with one rst_ack each; next frame starts again at D0.
- scan_valid=1 data AB during HDR → AB absent from output, header intact, error=1 until reset.
- reset asserted mid-header, then frame_start → all outputs 0 after the reset edge; full header restarts from ROM address 0; scan_done and rst_req in the same cycle → EOI emitted, no RST.
